// File: rtl/tcm_dport_arb_pkg.sv
// Shared types and defaults for the tcm_mem data-port arbiter.
// - mst_e      : master identifier carried through the ID FIFO
// - DEF_DEPTH  : default number of outstanding requests
// - DEF_TAG_W  : default request/response tag width
package tcm_dport_arb_pkg;

  typedef enum logic {
    MST_M0 = 1'b0,  // riscv_core data port
    MST_M1 = 1'b1   // loader / DMA requester
  } mst_e;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_TAG_W = 11;

endpackage

// File: rtl/tcm_dport_arb_id_fifo.sv
// In-order ID FIFO: remembers which master issued each outstanding request
// so the matching response can be routed back.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   push_i, push_id_i   store a master ID (ignored while full)
//   pop_i               drop the head entry (ignored while empty)
//   head_o              master ID at the head
//   full_o, empty_o     derived from the registered count
//   count_o             number of stored entries (0..DEPTH)
module tcm_dport_arb_id_fifo
  import tcm_dport_arb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  mst_e                     push_id_i,
  input  logic                     pop_i,
  output mst_e                     head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == FULL_CNT);
  assign empty_o = (count == '0);
  assign count_o = count;
  assign head_o  = mst_e'(mem[rd_ptr]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are PTR_W bits wide and wrap on their own; DEPTH is a power of 2.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tcm_dport_arb.sv
// Two-master arbiter in front of the tcm_mem data port.
// M0 = riscv_core data port, M1 = loader/DMA. tcm_mem sees a single requester;
// responses come back in order and are steered by an ID FIFO.
// Ports:
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   mN_* (N = 0, 1)                      master request inputs / response outputs
//   s_*_o                                request towards tcm_mem
//   s_*_i                                accept and response from tcm_mem
//   outstanding_o                        requests in flight
//   unexp_ack_o                          sticky: ack seen with no request in flight
//
// Handshake: a request is presented while rd or any write strobe is set and
// is held until the master sees mN_accept_o=1 in a cycle; that cycle the
// request is issued to tcm_mem (s_accept_i=1) and its master ID is queued.
module tcm_dport_arb
  import tcm_dport_arb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TAG_W = DEF_TAG_W,
  parameter bit RR_EN = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [31:0]            m0_addr_i,
  input  logic [31:0]            m0_data_wr_i,
  input  logic                   m0_rd_i,
  input  logic [3:0]             m0_wr_i,
  input  logic [TAG_W-1:0]       m0_req_tag_i,
  output logic                   m0_accept_o,
  output logic                   m0_ack_o,
  output logic [31:0]            m0_data_rd_o,
  output logic                   m0_error_o,
  output logic [TAG_W-1:0]       m0_resp_tag_o,
  input  logic [31:0]            m1_addr_i,
  input  logic [31:0]            m1_data_wr_i,
  input  logic                   m1_rd_i,
  input  logic [3:0]             m1_wr_i,
  input  logic [TAG_W-1:0]       m1_req_tag_i,
  output logic                   m1_accept_o,
  output logic                   m1_ack_o,
  output logic [31:0]            m1_data_rd_o,
  output logic                   m1_error_o,
  output logic [TAG_W-1:0]       m1_resp_tag_o,
  output logic [31:0]            s_addr_o,
  output logic [31:0]            s_data_wr_o,
  output logic                   s_rd_o,
  output logic [3:0]             s_wr_o,
  output logic [TAG_W-1:0]       s_req_tag_o,
  input  logic                   s_accept_i,
  input  logic                   s_ack_i,
  input  logic [31:0]            s_data_rd_i,
  input  logic                   s_error_i,
  input  logic [TAG_W-1:0]       s_resp_tag_i,
  output logic [$clog2(DEPTH):0] outstanding_o,
  output logic                   unexp_ack_o
);

  logic req0;
  logic req1;
  logic fifo_full;
  logic fifo_empty;
  logic gnt_vld;
  mst_e gnt_id;
  mst_e rr_ptr;
  mst_e head_id;
  logic issue;
  logic pop;

  assign req0 = m0_rd_i | (|m0_wr_i);
  assign req1 = m1_rd_i | (|m1_wr_i);

  // Grant depends only on requests, the RR pointer and the registered full
  // flag, so an ack in the same cycle never frees a slot combinationally.
  // Everything is forced idle while reset is asserted.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = MST_M0;
    if (rst_ni && !fifo_full) begin
      if (req0 && req1) begin
        gnt_vld = 1'b1;
        gnt_id  = RR_EN ? rr_ptr : MST_M0;
      end else if (req0) begin
        gnt_vld = 1'b1;
        gnt_id  = MST_M0;
      end else if (req1) begin
        gnt_vld = 1'b1;
        gnt_id  = MST_M1;
      end
    end
  end

  // Request mux: without a grant the strobes are low and the payload shows M0.
  always_comb begin
    s_addr_o    = m0_addr_i;
    s_data_wr_o = m0_data_wr_i;
    s_req_tag_o = m0_req_tag_i;
    s_rd_o      = 1'b0;
    s_wr_o      = 4'h0;
    if (!rst_ni) begin
      s_addr_o    = '0;
      s_data_wr_o = '0;
      s_req_tag_o = '0;
    end else if (gnt_vld && gnt_id == MST_M1) begin
      s_addr_o    = m1_addr_i;
      s_data_wr_o = m1_data_wr_i;
      s_req_tag_o = m1_req_tag_i;
      s_rd_o      = m1_rd_i;
      s_wr_o      = m1_wr_i;
    end else if (gnt_vld) begin
      s_rd_o      = m0_rd_i;
      s_wr_o      = m0_wr_i;
    end
  end

  // A grant always carries rd or a strobe, so grant+accept is an issue.
  assign issue       = gnt_vld && s_accept_i;
  assign m0_accept_o = issue && (gnt_id == MST_M0);
  assign m1_accept_o = issue && (gnt_id == MST_M1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= MST_M0;
    end else if (issue) begin
      rr_ptr <= (gnt_id == MST_M0) ? MST_M1 : MST_M0;
    end
  end

  tcm_dport_arb_id_fifo #(
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (issue),
    .push_id_i (gnt_id),
    .pop_i     (pop),
    .head_o    (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (outstanding_o)
  );

  // Response demux: an ack with nothing in flight is dropped here.
  assign pop      = s_ack_i && !fifo_empty;
  assign m0_ack_o = pop && (head_id == MST_M0);
  assign m1_ack_o = pop && (head_id == MST_M1);

  assign m0_data_rd_o  = m0_ack_o ? s_data_rd_i  : '0;
  assign m0_error_o    = m0_ack_o ? s_error_i    : 1'b0;
  assign m0_resp_tag_o = m0_ack_o ? s_resp_tag_i : '0;
  assign m1_data_rd_o  = m1_ack_o ? s_data_rd_i  : '0;
  assign m1_error_o    = m1_ack_o ? s_error_i    : 1'b0;
  assign m1_resp_tag_o = m1_ack_o ? s_resp_tag_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      unexp_ack_o <= 1'b0;
    end else if (s_ack_i && fifo_empty) begin
      unexp_ack_o <= 1'b1;
    end
  end

endmodule
